pipe_phy_lane_responder: RTL and testbench

//  Behavioural-synthesizable PHY end of one PIPE lane, facing the PCIe hard IP MAC in simulation-pipe mode.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_phy_lane_responder_if.sv | 32 +++
 rtl/pipe_delay_line.sv | 23 ++
 rtl/pipe_phy_lane_responder.sv | 132 +++++++++++++
 tb/tb_pipe_phy_lane_responder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - PIPE lane encodings, FSM states and counter helper
package pipe_pkg;

   localparam logic [1:0] PD_P0  = 2'b00;
   localparam logic [1:0] PD_P0S = 2'b01;
   localparam logic [1:0] PD_P1  = 2'b10;
   localparam logic [1:0] PD_P2  = 2'b11;

   localparam logic [2:0] RXSTAT_OK  = 3'b000;
   localparam logic [2:0] RXSTAT_DET = 3'b011;

   localparam int CNT_W = 16;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      RST_WAIT,
      IDLE,
      RATE,
      PD,
      RXDET
   } state_t;

   // Latency counters count down to zero, so an N-cycle wait loads N-1.
   function automatic cnt_t cnt_load(input int n);
      return cnt_t'(n - 1);
   endfunction

endpackage

// File: rtl/pipe_phy_lane_responder_if.sv
// rtl/pipe_phy_lane_responder_if.sv - PIPE lane signal bundle between MAC and PHY
interface pipe_phy_lane_responder_if #(
   parameter int DATA_W = 32,
   parameter int K_W    = 4
);
   logic [1:0]        pipe_powerdown;
   logic [1:0]        pipe_rate;
   logic              pipe_txdetectrx;
   logic              pipe_txelecidle;
   logic [DATA_W-1:0] pipe_txdata;
   logic [K_W-1:0]    pipe_txdatak;
   logic              pipe_phystatus;
   logic [2:0]        pipe_rxstatus;
   logic [DATA_W-1:0] pipe_rxdata;
   logic [K_W-1:0]    pipe_rxdatak;
   logic              pipe_rxvalid;
   logic              pipe_rxelecidle;

   modport master (
      output pipe_powerdown, pipe_rate, pipe_txdetectrx, pipe_txelecidle,
             pipe_txdata, pipe_txdatak,
      input  pipe_phystatus, pipe_rxstatus, pipe_rxdata, pipe_rxdatak,
             pipe_rxvalid, pipe_rxelecidle
   );

   modport slave (
      input  pipe_powerdown, pipe_rate, pipe_txdetectrx, pipe_txelecidle,
             pipe_txdata, pipe_txdatak,
      output pipe_phystatus, pipe_rxstatus, pipe_rxdata, pipe_rxdatak,
             pipe_rxvalid, pipe_rxelecidle
   );
endinterface

// File: rtl/pipe_delay_line.sv
// rtl/pipe_delay_line.sv - fixed-depth shift register with synchronous clear
module pipe_delay_line #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];
endmodule

// File: rtl/pipe_phy_lane_responder.sv
// rtl/pipe_phy_lane_responder.sv - PIPE lane PHY model: PhyStatus handshakes and TX->RX loopback
module pipe_phy_lane_responder
   import pipe_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int K_W          = 4,
   parameter int RST_CYCLES   = 8,
   parameter int RXDET_CYCLES = 16,
   parameter int RATE_CYCLES  = 8,
   parameter int PD_CYCLES    = 2,
   parameter int LOOP_LAT     = 2,
   parameter bit RX_PRESENT   = 1'b1
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   pipe_phy_lane_responder_if.slave  pipe,
   output logic                      busy
);
   localparam int LW = 1 + K_W + DATA_W;

   state_t     state, state_n;
   cnt_t       cnt, cnt_n;
   logic [1:0] pd_q, pd_n, rate_q, rate_n;
   logic [1:0] pd_tgt, pd_tgt_n, rate_tgt, rate_tgt_n;
   logic       det_armed, det_armed_n;
   logic       done;
   logic       v;
   logic [LW-1:0] loop_in, loop_out;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state     <= RST_WAIT;
         cnt       <= cnt_load(RST_CYCLES);
         pd_q      <= PD_P1;
         rate_q    <= 2'b00;
         pd_tgt    <= PD_P1;
         rate_tgt  <= 2'b00;
         det_armed <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pd_q      <= pd_n;
         rate_q    <= rate_n;
         pd_tgt    <= pd_tgt_n;
         rate_tgt  <= rate_tgt_n;
         det_armed <= det_armed_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      pd_n        = pd_q;
      rate_n      = rate_q;
      pd_tgt_n    = pd_tgt;
      rate_tgt_n  = rate_tgt;
      det_armed_n = det_armed | ~pipe.pipe_txdetectrx;
      done        = (cnt == '0);
      case (state)
         RST_WAIT: begin
            if (done) begin
               state_n = IDLE;
               pd_n    = pipe.pipe_powerdown;
               rate_n  = pipe.pipe_rate;
            end else begin
               cnt_n = cnt - cnt_t'(1);
            end
         end
         IDLE: begin
            // Requests that changed while busy are picked up here on return.
            if (pipe.pipe_rate != rate_q) begin
               state_n    = RATE;
               cnt_n      = cnt_load(RATE_CYCLES);
               rate_tgt_n = pipe.pipe_rate;
            end else if (pipe.pipe_powerdown != pd_q) begin
               state_n  = PD;
               cnt_n    = cnt_load(PD_CYCLES);
               pd_tgt_n = pipe.pipe_powerdown;
            end else if (pipe.pipe_txdetectrx && det_armed && pd_q == PD_P1) begin
               state_n = RXDET;
               cnt_n   = cnt_load(RXDET_CYCLES);
            end
         end
         RATE: begin
            if (done) begin
               state_n = IDLE;
               rate_n  = rate_tgt;
            end else begin
               cnt_n = cnt - cnt_t'(1);
            end
         end
         PD: begin
            if (done) begin
               state_n = IDLE;
               pd_n    = pd_tgt;
            end else begin
               cnt_n = cnt - cnt_t'(1);
            end
         end
         RXDET: begin
            if (done) begin
               state_n     = IDLE;
               det_armed_n = 1'b0;
            end else begin
               cnt_n = cnt - cnt_t'(1);
            end
         end
         default: state_n = RST_WAIT;
      endcase
   end

   assign pipe.pipe_phystatus = (state == RST_WAIT) ||
                                ((state inside {RATE, PD, RXDET}) && done);
   assign pipe.pipe_rxstatus  = (state == RXDET && done && RX_PRESENT) ? RXSTAT_DET : RXSTAT_OK;
   assign busy                = (state != IDLE);

   // Invalid words enter as zeros so leaving IDLE/P0 flushes the pipe behind the last valid word.
   assign v       = (state == IDLE) && (pd_q == PD_P0) && !pipe.pipe_txelecidle;
   assign loop_in = v ? {1'b1, pipe.pipe_txdatak, pipe.pipe_txdata} : '0;

   pipe_delay_line #(.W(LW), .DEPTH(LOOP_LAT)) u_loop (
      .clk    (clk_clk),
      .resetn (reset_reset_n),
      .din    (loop_in),
      .dout   (loop_out)
   );

   assign pipe.pipe_rxvalid    = loop_out[LW-1] && (state != RATE);
   assign pipe.pipe_rxelecidle = ~loop_out[LW-1];
   assign pipe.pipe_rxdatak    = loop_out[DATA_W +: K_W];
   assign pipe.pipe_rxdata     = loop_out[DATA_W-1:0];
endmodule

// File: tb/tb_pipe_phy_lane_responder.sv
// tb/tb_pipe_phy_lane_responder.sv - scoreboard bench for the PIPE lane responder
module tb_pipe_phy_lane_responder;
   import pipe_pkg::*;

   logic clk_clk = 1'b0;
   logic reset_reset_n;
   logic busy, busy0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   typedef struct { int cyc; logic [2:0] st; } pulse_t;
   typedef struct { int cyc; logic [31:0] d; logic [3:0] k; } word_t;
   pulse_t pq[$];
   word_t  wq[$];

   pipe_phy_lane_responder_if #(.DATA_W(32), .K_W(4)) p1 ();
   pipe_phy_lane_responder_if #(.DATA_W(32), .K_W(4)) p0 ();

   assign p0.pipe_powerdown  = p1.pipe_powerdown;
   assign p0.pipe_rate       = p1.pipe_rate;
   assign p0.pipe_txdetectrx = p1.pipe_txdetectrx;
   assign p0.pipe_txelecidle = p1.pipe_txelecidle;
   assign p0.pipe_txdata     = p1.pipe_txdata;
   assign p0.pipe_txdatak    = p1.pipe_txdatak;

   pipe_phy_lane_responder dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .pipe          (p1.slave),
      .busy          (busy)
   );

   pipe_phy_lane_responder #(.RX_PRESENT(1'b0)) dut_nodet (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .pipe          (p0.slave),
      .busy          (busy0)
   );

   always #5 clk_clk = ~clk_clk;
   always @(posedge clk_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   // PhyStatus / rxstatus monitor against the expected-pulse queue.
   always @(negedge clk_clk) begin
      if (mon_en && p1.pipe_phystatus) begin
         if (pq.size() == 0) begin
            check_eq("ph_unexpected", 64'd1, 64'd0);
         end else begin
            pulse_t e;
            e = pq.pop_front();
            check_eq("ph_cycle", 64'(cyc), 64'(e.cyc));
            check_eq("ph_rxstatus", 64'(p1.pipe_rxstatus), 64'(e.st));
            check_eq("nodet_ph", 64'(p0.pipe_phystatus), 64'd1);
            check_eq("nodet_rxstatus", 64'(p0.pipe_rxstatus), 64'(RXSTAT_OK));
         end
      end else begin
         check_eq("rxstatus_quiet", 64'(p1.pipe_rxstatus), 64'(RXSTAT_OK));
      end
   end

   // Loopback monitor against the expected-word queue.
   always @(negedge clk_clk) begin
      if (p1.pipe_rxvalid) begin
         if (wq.size() == 0) begin
            check_eq("rx_unexpected", 64'd1, 64'd0);
         end else begin
            word_t w;
            w = wq.pop_front();
            check_eq("rx_cycle", 64'(cyc), 64'(w.cyc));
            check_eq("rxdata", 64'(p1.pipe_rxdata), 64'(w.d));
            check_eq("rxdatak", 64'(p1.pipe_rxdatak), 64'(w.k));
            check_eq("rxelecidle_valid", 64'(p1.pipe_rxelecidle), 64'd0);
         end
      end
   end

   initial begin
      reset_reset_n      = 1'b0;
      p1.pipe_powerdown  = PD_P1;
      p1.pipe_rate       = 2'b00;
      p1.pipe_txdetectrx = 1'b0;
      p1.pipe_txelecidle = 1'b1;
      p1.pipe_txdata     = '0;
      p1.pipe_txdatak    = '0;
      repeat (3) step();

      @(negedge clk_clk);
      check_eq("rst_ph", 64'(p1.pipe_phystatus), 64'd1);
      check_eq("rst_busy", 64'(busy), 64'd1);
      check_eq("rst_rxelecidle", 64'(p1.pipe_rxelecidle), 64'd1);
      check_eq("rst_rxvalid", 64'(p1.pipe_rxvalid), 64'd0);
      check_eq("rst_rxdata", 64'(p1.pipe_rxdata), 64'd0);
      step();
      reset_reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_clk);
         check_eq("rstwait_ph", 64'(p1.pipe_phystatus), 64'd1);
         step();
      end
      @(negedge clk_clk);
      check_eq("ready_ph", 64'(p1.pipe_phystatus), 64'd0);
      check_eq("ready_busy", 64'(busy), 64'd0);
      check_eq("ready_rxelecidle", 64'(p1.pipe_rxelecidle), 64'd1);
      mon_en = 1'b1;
      step();

      // Receiver detect held long: one pulse only; then drop and re-raise.
      p1.pipe_txdetectrx = 1'b1;
      pq.push_back(pulse_t'{cyc + 16, RXSTAT_DET});
      repeat (5) step();
      @(negedge clk_clk);
      check_eq("det_busy", 64'(busy), 64'd1);
      repeat (35) step();
      p1.pipe_txdetectrx = 1'b0;
      repeat (2) step();
      p1.pipe_txdetectrx = 1'b1;
      pq.push_back(pulse_t'{cyc + 16, RXSTAT_DET});
      repeat (20) step();
      p1.pipe_txdetectrx = 1'b0;
      step();

      // P1 -> P0, then loop back a stream of words.
      p1.pipe_powerdown  = PD_P0;
      p1.pipe_txelecidle = 1'b0;
      p1.pipe_txdata     = 32'hBC1C1C1C;
      p1.pipe_txdatak    = 4'h1;
      pq.push_back(pulse_t'{cyc + 2, RXSTAT_OK});
      repeat (3) step();
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            p1.pipe_txdata  = $urandom;
            p1.pipe_txdatak = 4'($urandom_range(0, 15));
         end
         wq.push_back(word_t'{cyc + 2, p1.pipe_txdata, p1.pipe_txdatak});
         step();
      end

      // Last two words drain into the RATE window and must be dropped.
      p1.pipe_txdata = 32'h11111111;
      step();
      p1.pipe_txdata     = 32'h22222222;
      p1.pipe_rate       = 2'b01;
      p1.pipe_powerdown  = PD_P1;
      pq.push_back(pulse_t'{cyc + 8, RXSTAT_OK});
      pq.push_back(pulse_t'{cyc + 11, RXSTAT_OK});
      step();
      p1.pipe_txelecidle = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_clk);
         check_eq("rate_rxvalid", 64'(p1.pipe_rxvalid), 64'd0);
         step();
      end
      repeat (8) step();

      // Reset in the middle of a detect: its pulse must never appear.
      p1.pipe_txdetectrx = 1'b1;
      repeat (5) step();
      reset_reset_n = 1'b0;
      mon_en        = 1'b0;
      pq.delete();
      step();
      @(negedge clk_clk);
      check_eq("abort_ph", 64'(p1.pipe_phystatus), 64'd1);
      check_eq("abort_rxstatus", 64'(p1.pipe_rxstatus), 64'(RXSTAT_OK));
      check_eq("abort_busy", 64'(busy), 64'd1);
      check_eq("abort_rxelecidle", 64'(p1.pipe_rxelecidle), 64'd1);
      repeat (2) step();
      reset_reset_n      = 1'b1;
      p1.pipe_txdetectrx = 1'b0;
      repeat (10) step();
      mon_en = 1'b1;
      repeat (20) step();

      check_eq("pulse_queue_empty", 64'(pq.size()), 64'd0);
      check_eq("word_queue_empty", 64'(wq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
